// File: rtl/string_op_ctrl.sv
// string_op_ctrl: command-driven controller for a fixed-length character
// buffer. It supports load, clear and single-character put/get operations,
// plus multi-cycle case conversion, length and compare operations that walk
// the buffer one index per cycle.
//
// Optional feature: define STRING_OP_ICOMPARE_EN to enable case-insensitive
// COMPARE. When enabled, cmd_chr[0] = 1 selects case-insensitive matching.
// With the macro undefined, COMPARE is always case-sensitive and ignores
// cmd_chr.
module string_op_ctrl #(
    parameter int WS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_vld,
    output logic               cmd_rdy,
    input  logic [2:0]         cmd_op,
    input  logic [7:0]         cmd_idx,
    input  logic [7:0]         cmd_chr,
    input  logic [0:WS-1][7:0] cmd_str,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [7:0]         rsp_dat,
    output logic [0:WS-1][7:0] buf_o
);

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_PUTC    = 3'd1;
    localparam logic [2:0] OP_GETC    = 3'd2;
    localparam logic [2:0] OP_TOUPPER = 3'd3;
    localparam logic [2:0] OP_TOLOWER = 3'd4;
    localparam logic [2:0] OP_LEN     = 3'd5;
    localparam logic [2:0] OP_COMPARE = 3'd6;
    localparam logic [2:0] OP_CLEAR   = 3'd7;

    localparam logic [7:0] WS_L    = 8'(WS);
    localparam logic [7:0] WS_LAST = 8'(WS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ASCII case helpers; bytes outside the letter ranges pass through.
    function automatic logic [7:0] f_to_upper(input logic [7:0] c);
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            return c - 8'h20;
        end else begin
            return c;
        end
    endfunction

    function automatic logic [7:0] f_to_lower(input logic [7:0] c);
        if ((c >= 8'h41) && (c <= 8'h5A)) begin
            return c + 8'h20;
        end else begin
            return c;
        end
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [0:WS-1][7:0] r_buf;
    logic [0:WS-1][7:0] w_buf_nxt;
    logic [0:WS-1][7:0] r_str;
    logic [2:0]         r_op;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic [7:0]         r_rsp_dat;
    logic [7:0]         w_rsp_dat_nxt;
    logic               r_cmd_rdy;
    logic               r_rsp_vld;

    logic               w_capture;
    logic               w_load_all;
    logic               w_clear_all;
    logic               w_wr_en;
    logic [7:0]         w_wr_idx;
    logic [7:0]         w_wr_dat;

    logic [7:0]         w_cur_buf;
    logic [7:0]         w_cur_str;
    logic [7:0]         w_get_byte;
    logic [7:0]         w_conv;
    logic [7:0]         w_cmp_a;
    logic [7:0]         w_cmp_b;

    // Select the bytes at the RUN counter and at cmd_idx; indices past the end read as zero.
    always_comb begin
        w_cur_buf  = 8'h00;
        w_cur_str  = 8'h00;
        w_get_byte = 8'h00;
        for (int i = 0; i < WS; i++) begin
            w_cur_buf  = w_cur_buf  | (r_buf[i] & {8{r_cnt == 8'(i)}});
            w_cur_str  = w_cur_str  | (r_str[i] & {8{r_cnt == 8'(i)}});
            w_get_byte = w_get_byte | (r_buf[i] & {8{cmd_idx == 8'(i)}});
        end
    end

    assign w_conv = (r_op == OP_TOUPPER) ? f_to_upper(w_cur_buf) : f_to_lower(w_cur_buf);

`ifdef STRING_OP_ICOMPARE_EN
    logic r_icase;

    // Remember the case-insensitive option of the accepted command.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_icase <= 1'b0;
        end else if (w_capture) begin
            r_icase <= cmd_chr[0];
        end
    end

    assign w_cmp_a = r_icase ? f_to_lower(w_cur_buf) : w_cur_buf;
    assign w_cmp_b = r_icase ? f_to_lower(w_cur_str) : w_cur_str;
`else
    assign w_cmp_a = w_cur_buf;
    assign w_cmp_b = w_cur_str;
`endif

    // FSM next state plus the datapath controls for accept and each RUN step.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rsp_dat_nxt = r_rsp_dat;
        w_capture     = 1'b0;
        w_load_all    = 1'b0;
        w_clear_all   = 1'b0;
        w_wr_en       = 1'b0;
        w_wr_idx      = 8'h00;
        w_wr_dat      = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (cmd_vld) begin
                    w_capture     = 1'b1;
                    w_cnt_nxt     = 8'h00;
                    w_rsp_dat_nxt = 8'h00;
                    case (cmd_op)
                        OP_LOAD: begin
                            w_load_all  = 1'b1;
                            w_state_nxt = ST_RESP;
                        end
                        OP_PUTC: begin
                            w_wr_en     = (cmd_idx < WS_L) && (cmd_chr != 8'h00);
                            w_wr_idx    = cmd_idx;
                            w_wr_dat    = cmd_chr;
                            w_state_nxt = ST_RESP;
                        end
                        OP_GETC: begin
                            w_rsp_dat_nxt = w_get_byte;
                            w_state_nxt   = ST_RESP;
                        end
                        OP_CLEAR: begin
                            w_clear_all = 1'b1;
                            w_state_nxt = ST_RESP;
                        end
                        OP_TOUPPER, OP_TOLOWER, OP_LEN, OP_COMPARE: begin
                            w_state_nxt = ST_RUN;
                        end
                        default: begin
                            w_state_nxt = ST_RESP;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                case (r_op)
                    OP_TOUPPER, OP_TOLOWER: begin
                        w_wr_en  = 1'b1;
                        w_wr_idx = r_cnt;
                        w_wr_dat = w_conv;
                        if (r_cnt == WS_LAST) begin
                            w_rsp_dat_nxt = 8'h00;
                            w_state_nxt   = ST_RESP;
                        end else begin
                            w_cnt_nxt = r_cnt + 8'h01;
                        end
                    end
                    OP_LEN: begin
                        if (w_cur_buf == 8'h00) begin
                            w_rsp_dat_nxt = r_cnt;
                            w_state_nxt   = ST_RESP;
                        end else if (r_cnt == WS_LAST) begin
                            w_rsp_dat_nxt = WS_L;
                            w_state_nxt   = ST_RESP;
                        end else begin
                            w_cnt_nxt = r_cnt + 8'h01;
                        end
                    end
                    OP_COMPARE: begin
                        if (w_cmp_a < w_cmp_b) begin
                            w_rsp_dat_nxt = 8'hFF;
                            w_state_nxt   = ST_RESP;
                        end else if (w_cmp_a > w_cmp_b) begin
                            w_rsp_dat_nxt = 8'h01;
                            w_state_nxt   = ST_RESP;
                        end else if ((w_cmp_a == 8'h00) || (r_cnt == WS_LAST)) begin
                            w_rsp_dat_nxt = 8'h00;
                            w_state_nxt   = ST_RESP;
                        end else begin
                            w_cnt_nxt = r_cnt + 8'h01;
                        end
                    end
                    default: begin
                        w_rsp_dat_nxt = 8'h00;
                        w_state_nxt   = ST_RESP;
                    end
                endcase
            end
            ST_RESP: begin
                if (rsp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next buffer contents: whole-buffer clear/load wins over a single-byte write.
    always_comb begin
        w_buf_nxt = r_buf;
        for (int i = 0; i < WS; i++) begin
            w_buf_nxt[i] = w_clear_all ? 8'h00 :
                           w_load_all  ? cmd_str[i] :
                           (w_wr_en && (w_wr_idx == 8'(i))) ? w_wr_dat : r_buf[i];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf     <= {WS{8'h00}};
            r_str     <= {WS{8'h00}};
            r_op      <= OP_LOAD;
            r_cnt     <= 8'h00;
            r_rsp_dat <= 8'h00;
            r_cmd_rdy <= 1'b1;
            r_rsp_vld <= 1'b0;
        end else begin
            r_buf     <= w_buf_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rsp_dat <= w_rsp_dat_nxt;
            r_cmd_rdy <= (w_state_nxt == ST_IDLE);
            r_rsp_vld <= (w_state_nxt == ST_RESP);
            if (w_capture) begin
                r_str <= cmd_str;
                r_op  <= cmd_op;
            end
        end
    end

    assign cmd_rdy = r_cmd_rdy;
    assign rsp_vld = r_rsp_vld;
    assign rsp_dat = r_rsp_dat;
    assign buf_o   = r_buf;

endmodule

// File: tb/tb_string_op_ctrl.sv
// Self-checking bench for string_op_ctrl: directed vectors plus randomized
// commands compared against a byte-array reference model.
module tb_string_op_ctrl;

    localparam int WS = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_vld;
    logic               cmd_rdy;
    logic [2:0]         cmd_op;
    logic [7:0]         cmd_idx;
    logic [7:0]         cmd_chr;
    logic [0:WS-1][7:0] cmd_str;
    logic               rsp_vld;
    logic               rsp_rdy;
    logic [7:0]         rsp_dat;
    logic [0:WS-1][7:0] buf_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] m_buf [WS];

    string_op_ctrl #(.WS(WS)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_vld (cmd_vld),
        .cmd_rdy (cmd_rdy),
        .cmd_op  (cmd_op),
        .cmd_idx (cmd_idx),
        .cmd_chr (cmd_chr),
        .cmd_str (cmd_str),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_dat (rsp_dat),
        .buf_o   (buf_o)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_packed();
        logic [63:0] p;
        for (int i = 0; i < WS; i++) p[63-8*i -: 8] = m_buf[i];
        return p;
    endfunction

    function automatic logic [7:0] lc(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
    endfunction

    // Reference model: applies one command to m_buf, gives response and the
    // number of clock edges from accept to rsp_vld becoming visible.
    task automatic model_cmd(input logic [2:0] op, input logic [7:0] idx, input logic [7:0] chr,
                             input logic [63:0] s, output logic [7:0] rsp, output int lat);
        logic [7:0] a;
        logic [7:0] b;
        bit icase;
        int n;
        bit done;
`ifdef STRING_OP_ICOMPARE_EN
        icase = chr[0];
`else
        icase = 1'b0;
`endif
        rsp = 8'h00;
        lat = 1;
        case (op)
            3'd0: for (int i = 0; i < WS; i++) m_buf[i] = s[63-8*i -: 8];
            3'd1: if (int'(idx) < WS && chr != 8'h00) m_buf[idx] = chr;
            3'd2: rsp = (int'(idx) < WS) ? m_buf[idx] : 8'h00;
            3'd3: begin
                for (int i = 0; i < WS; i++)
                    if (m_buf[i] >= 8'h61 && m_buf[i] <= 8'h7A) m_buf[i] = m_buf[i] - 8'h20;
                lat = WS + 1;
            end
            3'd4: begin
                for (int i = 0; i < WS; i++) m_buf[i] = lc(m_buf[i]);
                lat = WS + 1;
            end
            3'd5: begin
                n = 0;
                while (n < WS && m_buf[n] != 8'h00) n++;
                rsp = 8'(n);
                lat = ((n < WS) ? n + 1 : WS) + 1;
            end
            3'd6: begin
                done = 1'b0;
                lat = WS + 1;
                for (int i = 0; i < WS; i++) begin
                    if (!done) begin
                        a = icase ? lc(m_buf[i]) : m_buf[i];
                        b = icase ? lc(s[63-8*i -: 8]) : s[63-8*i -: 8];
                        if (a != b) begin
                            rsp = (a < b) ? 8'hFF : 8'h01;
                            lat = i + 2;
                            done = 1'b1;
                        end else if (a == 8'h00) begin
                            lat = i + 2;
                            done = 1'b1;
                        end
                    end
                end
            end
            default: for (int i = 0; i < WS; i++) m_buf[i] = 8'h00;
        endcase
    endtask

    // Issue one command from IDLE, check latency, response, hold stability,
    // handshake release and the resulting buffer against the model.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] idx,
                           input logic [7:0] chr, input logic [63:0] s, input int hold,
                           output logic [7:0] got, output int lat);
        logic [7:0] exp_rsp;
        int exp_lat;
        bit rdy_seen;
        bit unstable;
        logic [7:0] held;
        model_cmd(op, idx, chr, s, exp_rsp, exp_lat);
        cmd_vld = 1'b1;
        cmd_op  = op;
        cmd_idx = idx;
        cmd_chr = chr;
        cmd_str = s;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        cmd_str = {$urandom, $urandom};
        cmd_chr = 8'($urandom);
        cmd_idx = 8'($urandom);
        lat = 1;
        rdy_seen = 1'b0;
        while (!rsp_vld && lat < 400) begin
            if (cmd_rdy) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check_value({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_value({tag, " rsp_dat"}, 64'(rsp_dat), 64'(exp_rsp));
        got = rsp_dat;
        held = rsp_dat;
        unstable = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (!rsp_vld || rsp_dat != held || cmd_rdy) unstable = 1'b1;
        end
        check_value({tag, " busy/hold"}, {61'd0, unstable, rdy_seen, cmd_rdy}, 64'd0);
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        check_value({tag, " release"}, {62'd0, rsp_vld, cmd_rdy}, 64'd1);
        check_value({tag, " buf_o"}, 64'(buf_o), model_packed());
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] edges [8];
        int r;
        edges = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};
        r = $urandom_range(0, 9);
        if (r == 0) return 8'h00;
        else if (r <= 3) return 8'h61 + 8'($urandom_range(0, 25));
        else if (r <= 6) return 8'h41 + 8'($urandom_range(0, 25));
        else if (r == 7) return 8'($urandom_range(0, 255));
        else return edges[$urandom_range(0, 7)];
    endfunction

    initial begin
        logic [7:0]  got;
        int          lat;
        logic [2:0]  op;
        logic [63:0] s;
        int          r;
        int          p;

        rst = 1'b1; cmd_vld = 1'b0; cmd_op = 3'd0; cmd_idx = 8'h00;
        cmd_chr = 8'h00; cmd_str = 64'h0; rsp_rdy = 1'b0;
        for (int i = 0; i < WS; i++) m_buf[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        check_value("reset state", {cmd_rdy, rsp_vld, rsp_dat, 64'(buf_o)}, {1'b1, 1'b0, 8'h00, 64'h0});

        // Load/get/put vectors
        run_cmd("load hello", 3'd0, 8'd0, 8'h00, 64'h48656C6C6F2C2077, 0, got, lat);
        run_cmd("getc 0", 3'd2, 8'd0, 8'h00, 64'h0, 1, got, lat);
        check_value("getc 0 const", 64'(got), 64'h48);
        run_cmd("getc 7", 3'd2, 8'd7, 8'h00, 64'h0, 0, got, lat);
        check_value("getc 7 const", 64'(got), 64'h77);
        run_cmd("getc 9", 3'd2, 8'd9, 8'h00, 64'h0, 0, got, lat);
        check_value("getc 9 const", 64'(got), 64'h00);
        run_cmd("putc 7", 3'd1, 8'd7, 8'h3F, 64'h0, 0, got, lat);
        check_value("putc 7 const", 64'(buf_o), 64'h48656C6C6F2C203F);
        run_cmd("putc nul", 3'd1, 8'd7, 8'h00, 64'h0, 0, got, lat);
        check_value("putc nul const", 64'(buf_o), 64'h48656C6C6F2C203F);

        // Length and case conversion
        run_cmd("load janez", 3'd0, 8'd0, 8'h00, 64'h4A616E657A000000, 0, got, lat);
        run_cmd("len janez", 3'd5, 8'd0, 8'h00, 64'h0, 5, got, lat);
        check_value("len janez const", {56'd0, got}, 64'h05);
        check_value("len janez lat", 64'(lat), 64'd7);
        run_cmd("toupper janez", 3'd3, 8'd0, 8'h00, 64'h0, 0, got, lat);
        check_value("toupper const", 64'(buf_o), 64'h4A414E455A000000);

        // Compare
        run_cmd("load hello2", 3'd0, 8'd0, 8'h00, 64'h48656C6C6F2C2077, 0, got, lat);
        run_cmd("cmp smaller", 3'd6, 8'd0, 8'h00, 64'h4A616E6572204E6F, 2, got, lat);
        check_value("cmp smaller const", {56'd0, got}, 64'hFF);
        run_cmd("cmp equal", 3'd6, 8'd0, 8'h00, 64'h48656C6C6F2C2077, 0, got, lat);
        check_value("cmp equal const", {56'd0, got, 32'(lat)}, {56'd0, 8'h00, 32'd9});
`ifdef STRING_OP_ICOMPARE_EN
        run_cmd("load JANEZ", 3'd0, 8'd0, 8'h00, 64'h4A414E455A204E4F, 0, got, lat);
        run_cmd("icmp on", 3'd6, 8'd0, 8'h01, 64'h6A616E657A206E6F, 0, got, lat);
        check_value("icmp on const", {56'd0, got}, 64'h00);
        run_cmd("icmp off", 3'd6, 8'd0, 8'h00, 64'h6A616E657A206E6F, 0, got, lat);
        check_value("icmp off const", {56'd0, got}, 64'hFF);
`endif

        // Reset in the middle of TOUPPER
        run_cmd("load hello3", 3'd0, 8'd0, 8'h00, 64'h48656C6C6F2C2077, 0, got, lat);
        cmd_vld = 1'b1; cmd_op = 3'd3;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_value("toupper partial", 64'(buf_o), 64'h48456C6C6F2C2077);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < WS; i++) m_buf[i] = 8'h00;
        check_value("rst in run", {cmd_rdy, rsp_vld, rsp_dat, 64'(buf_o)}, {1'b1, 1'b0, 8'h00, 64'h0});
        r = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_vld) r = 1;
        end
        check_value("no rsp after rst", 64'(r), 64'd0);

        // Randomized commands
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2: op = 3'd0;
                3:       op = 3'd1;
                4:       op = 3'd2;
                5:       op = 3'd3;
                6:       op = 3'd4;
                7, 8:    op = 3'd5;
                9, 10:   op = 3'd6;
                default: op = 3'd7;
            endcase
            for (int i = 0; i < WS; i++) s[63-8*i -: 8] = rand_byte();
            if (op == 3'd6 && $urandom_range(0, 2) != 0) begin
                s = model_packed();
                p = $urandom_range(0, WS - 1);
                if ($urandom_range(0, 1) == 1) s[63-8*p -: 8] = rand_byte();
                if ($urandom_range(0, 1) == 1) s[63-8*p -: 8] = s[63-8*p -: 8] ^ 8'h20;
            end
            run_cmd("rnd", op, 8'($urandom_range(0, 10)),
                    ($urandom_range(0, 3) == 0) ? 8'h00 : rand_byte() | 8'($urandom_range(0, 1)),
                    s, $urandom_range(0, 3), got, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/string_op_ctrl.md
STRING_OP_CTRL -- requirements
Module: string_op_ctrl

Interface
REQ-001 SHALL have parameter WS, default 8: buffer length in characters, legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_vld  input  1  command valid.
REQ-005 SHALL have port cmd_rdy  output  1  command ready.
REQ-006 SHALL have port cmd_op  input  3  opcode: 0 LOAD, 1 PUTC, 2 GETC, 3 TOUPPER, 4 TOLOWER, 5 LEN, 6 COMPARE, 7 CLEAR.
REQ-007 SHALL have port cmd_idx  input  8  character index for PUTC/GETC.
REQ-008 SHALL have port cmd_chr  input  8  character for PUTC; option bits for COMPARE.
REQ-009 SHALL have port cmd_str  input  WS*8  operand string for LOAD/COMPARE, packed [0:WS-1][7:0], index 0 = MSB byte.
REQ-010 SHALL have port rsp_vld  output  1  response valid.
REQ-011 SHALL have port rsp_rdy  input  1  response ready.
REQ-012 SHALL have port rsp_dat  output  8  response data.
REQ-013 SHALL have port buf_o  output  WS*8  current buffer, same packing as cmd_str.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, RESP; cmd_rdy = 1 only in IDLE.
REQ-015 SHALL accept a command on the edge where cmd_vld & cmd_rdy.
REQ-016 LOAD, PUTC, GETC, CLEAR SHALL go IDLE->RESP on accept; rsp_vld high the following cycle.
REQ-017 TOUPPER, TOLOWER, LEN, COMPARE SHALL go IDLE->RUN, processing one index per RUN cycle from 0 upward with an internal counter.
REQ-018 LOAD SHALL copy cmd_str to the buffer; CLEAR SHALL zero it; rsp_dat = 0.
REQ-019 PUTC SHALL write cmd_chr at cmd_idx; no write if cmd_idx >= WS or cmd_chr == 0; rsp_dat = 0.
REQ-020 GETC SHALL return buffer[cmd_idx], or 0 if cmd_idx >= WS.
REQ-021 TOUPPER SHALL subtract 8'h20 from bytes 8'h61..8'h7A; TOLOWER SHALL add 8'h20 to bytes 8'h41..8'h5A; other bytes unchanged; exactly WS RUN cycles; rsp_dat = 0.
REQ-022 LEN SHALL count bytes from index 0 up to the first 8'h00, leaving RUN on that byte or after index WS-1; rsp_dat = count (0..WS).
REQ-023 COMPARE SHALL compare buffer vs cmd_str, unsigned bytewise from index 0; first differing byte ends RUN with rsp_dat = 8'hFF (buffer smaller) or 8'h01 (larger); both bytes 8'h00 or index WS-1 equal ends with 8'h00.
REQ-024 cmd_str and cmd_chr SHALL be captured at accept; later input changes SHALL not affect an in-flight command.
REQ-025 In RESP, rsp_vld = 1 and rsp_dat stable until rsp_vld & rsp_rdy, then IDLE; a new command accepted no earlier than the cycle after the handshake.
REQ-026 buf_o SHALL reflect each buffer update the cycle after it is written.

Reset
REQ-027 rst SHALL force IDLE, buffer = 0, counter = 0, rsp_vld = 0, rsp_dat = 0, cmd_rdy = 1 in the cycle after the sampling edge.
REQ-028 rst during RUN or RESP SHALL abandon the command with no response; partial TOUPPER/TOLOWER results SHALL be discarded by the buffer clear.

Configuration
REQ-029 With STRING_OP_ICOMPARE_EN defined, COMPARE with cmd_chr[0] = 1 SHALL fold both operands to lower case before each byte comparison.
REQ-030 Without STRING_OP_ICOMPARE_EN, cmd_chr SHALL be ignored for COMPARE and comparison SHALL be case-sensitive.

Verification
REQ-031 LOAD 64'h48656C6C6F2C2077 ("Hello, w") then GETC idx 0 and 7 -> rsp_dat 8'h48, 8'h77; GETC idx 9 -> 8'h00.
REQ-032 LOAD "Hello, w"; PUTC idx 7 chr 8'h3F -> buf_o 64'h48656C6C6F2C203F; PUTC idx 7 chr 8'h00 -> buf_o unchanged.
REQ-033 LOAD 64'h4A616E657A00_0000 ("Janez"); LEN -> 8'h05 with rsp_vld 7 cycles after accept (5 counted bytes + NUL byte + RESP); TOUPPER -> buf_o 64'h4A414E455A000000.
REQ-034 LOAD "Hello, w"; COMPARE "Janez No" -> 8'hFF after one RUN cycle; COMPARE "Hello, w" -> 8'h00 after 8 RUN cycles.
REQ-035 With STRING_OP_ICOMPARE_EN: LOAD "JANEZ NO"; COMPARE "janez no" chr 8'h01 -> 8'h00; chr 8'h00 -> 8'hFF.
REQ-036 TOUPPER in RUN, assert rst at RUN cycle 3 -> next cycle IDLE, buf_o = 0, no rsp_vld; hold rsp_rdy = 0 for 5 cycles on any response -> rsp_vld and rsp_dat stable, cmd_rdy = 0 throughout.
